axi4_lite_reg_slave: RTL and testbench
======================================

AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register/bus width; legal values 32, 64.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count (1..256).
REQ-004 SHALL have parameter RO_MASK [NUM_REGS], default all-0; bit i set = register i read-only, sourced from hw_rd_data.
REQ-005 SHALL have parameter PRIV_ONLY, default 0; 1 = unprivileged (prot[0]=0) accesses rejected.
REQ-006 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-007 SHALL have write address ports: awvalid in 1; awready out 1; awaddr in ADDR_WIDTH; awprot in 3.
REQ-008 SHALL have write data ports: wvalid in 1; wready out 1; wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8.
REQ-009 SHALL have write response ports: bvalid out 1; bready in 1; bresp out 2.
REQ-010 SHALL have read ports: arvalid in 1; arready out 1; araddr in ADDR_WIDTH; arprot in 3; rvalid out 1; rready in 1; rdata out DATA_WIDTH; rresp out 2.
REQ-011 SHALL have register-side ports: reg_q out NUM_REGS*DATA_WIDTH (flattened RW contents); hw_rd_data in NUM_REGS*DATA_WIDTH; reg_wr_pulse out NUM_REGS; reg_rd_pulse out NUM_REGS.

Function
REQ-012 SHALL decode index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low byte-offset bits ignored.
REQ-013 SHALL respond DECERR (2'b11) with no side effect when index >= NUM_REGS.
REQ-014 SHALL respond SLVERR (2'b10) with no side effect on writes to RO registers, or on any access with PRIV_ONLY=1 and prot[0]=0; otherwise OKAY (2'b00).
REQ-015 SHALL accept AW and W independently: awready = !aw_held && !bvalid; wready = !w_held && !bvalid; each handshake latches its channel.
REQ-016 SHALL commit a write on the edge where AW (held or handshaking) and W (held or handshaking) are both present; bvalid rises the following cycle; held flags clear.
REQ-017 SHALL update only bytes with wstrb set; wstrb=0 still produces OKAY and reg_wr_pulse.
REQ-018 SHALL pulse reg_wr_pulse[index] for exactly one cycle coincident with bvalid rising, only on OKAY writes.
REQ-019 SHALL hold bvalid/bresp stable until bready; the next write may commit no earlier than the cycle after the B handshake.
REQ-020 SHALL set arready = !rvalid; on AR handshake, rvalid rises next cycle with rdata/rresp; reg_rd_pulse[index] pulses one cycle at that handshake (OKAY only).
REQ-021 SHALL return reg_q slice for RW registers, hw_rd_data slice sampled at AR handshake for RO registers, 0 on error.
REQ-022 SHALL hold rdata/rresp stable while rvalid && !rready.
REQ-023 SHALL, for same-cycle read and write commit to one register, return the pre-write value.
REQ-024 SHALL operate the read and write paths fully concurrently; no arbitration stall.

Reset
REQ-025 SHALL, while rst=1, force awready, wready, arready, bvalid, rvalid, reg_wr_pulse, reg_rd_pulse = 0; bresp, rresp, rdata = 0; all RW registers = 0; held flags cleared.
REQ-026 SHALL discard any partially captured AW/W and pending B/R on reset mid-transaction; ready outputs assert the first cycle after rst deasserts.

Structure
REQ-027 SHALL take response encodings OKAY/EXOKAY/SLVERR/DECERR as 2-bit typed constants and prot bit positions from the shared axi4_lite_pkg; width parameters stay module parameters.
REQ-028 SHALL place AW/W capture and join logic in one sub-module axi4_lite_aw_w_join; read path and register array stay in the top module.

Verification (NUM_REGS=8, DATA_WIDTH=32, RO_MASK=8'h80)
REQ-029 AW 0x04 and W 0xDEADBEEF strb 4'hF in same cycle -> bvalid next cycle, bresp=OKAY, reg_wr_pulse[1] one cycle; read 0x04 -> rdata=0xDEADBEEF.
REQ-030 W 0x11223344 strb 4'b0101 three cycles before AW 0x08 over reg value 0 -> commit on AW handshake, reg 2 = 0x00220044.
REQ-031 Write 0x1C (RO) -> SLVERR, no pulse; read 0x1C with hw_rd_data[7]=0xCAFE0001 -> rdata=0xCAFE0001, OKAY; read 0x20 -> DECERR, rdata=0.
REQ-032 bready low 5 cycles -> bvalid/bresp stable, awready/wready low throughout; rready low 5 cycles -> rdata stable, arready low.
REQ-033 Same-cycle write 0x5 and read to reg 3 holding 0xA -> rdata=0xA, reg 3 = 0x5 afterwards.
REQ-034 rst asserted after AW captured, before W -> all outputs 0; post-reset W alone produces no bvalid.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, prot bit positions and the
// AW/W join state encoding.
package axi4_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  localparam int PROT_PRIV_BIT   = 0;
  localparam int PROT_NONSEC_BIT = 1;
  localparam int PROT_INSTR_BIT  = 2;

  typedef enum logic [1:0] {
    JOIN_IDLE    = 2'd0,
    JOIN_AW_HELD = 2'd1,
    JOIN_W_HELD  = 2'd2,
    JOIN_RESP    = 2'd3
  } join_state_e;

endpackage

// File: rtl/axi4_lite_aw_w_join.sv
// Captures AW and W independently, joins them into a single-cycle commit
// strobe and owns the B channel until the response is accepted.
module axi4_lite_aw_w_join
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output axi_resp_t               bresp,
  output logic                    commit,
  output logic [ADDR_WIDTH-1:0]   commit_addr,
  output logic [2:0]              commit_prot,
  output logic [DATA_WIDTH-1:0]   commit_data,
  output logic [DATA_WIDTH/8-1:0] commit_strb,
  input  axi_resp_t               commit_resp,
  output join_state_e             state
);

  join_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic [2:0]              aw_prot_q, aw_prot_d;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
  axi_resp_t               bresp_q, bresp_d;
  logic aw_hs, w_hs, aw_present, w_present;

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // valid never waits on ready, and ready is withdrawn while a channel is
  // held or a write response is outstanding.
  always_comb begin
    awready     = !rst && (state_q == JOIN_IDLE || state_q == JOIN_W_HELD);
    wready      = !rst && (state_q == JOIN_IDLE || state_q == JOIN_AW_HELD);
    aw_hs       = awvalid && awready;
    w_hs        = wvalid && wready;
    aw_present  = (state_q == JOIN_AW_HELD) || aw_hs;
    w_present   = (state_q == JOIN_W_HELD) || w_hs;
    commit      = aw_present && w_present;
    commit_addr = (state_q == JOIN_AW_HELD) ? aw_addr_q : awaddr;
    commit_prot = (state_q == JOIN_AW_HELD) ? aw_prot_q : awprot;
    commit_data = (state_q == JOIN_W_HELD) ? w_data_q : wdata;
    commit_strb = (state_q == JOIN_W_HELD) ? w_strb_q : wstrb;
    aw_addr_d   = aw_hs ? awaddr : aw_addr_q;
    aw_prot_d   = aw_hs ? awprot : aw_prot_q;
    w_data_d    = w_hs ? wdata : w_data_q;
    w_strb_d    = w_hs ? wstrb : w_strb_q;
    bresp_d     = commit ? commit_resp : bresp_q;
    state_d     = state_q;
    case (state_q)
      JOIN_IDLE: begin
        if (commit)     state_d = JOIN_RESP;
        else if (aw_hs) state_d = JOIN_AW_HELD;
        else if (w_hs)  state_d = JOIN_W_HELD;
      end
      JOIN_AW_HELD: if (commit) state_d = JOIN_RESP;
      JOIN_W_HELD:  if (commit) state_d = JOIN_RESP;
      JOIN_RESP:    if (bready) state_d = JOIN_IDLE;
      default:      state_d = JOIN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= JOIN_IDLE;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_addr_q <= aw_addr_d;
      aw_prot_q <= aw_prot_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
    end
  end

  assign bvalid = (state_q == JOIN_RESP);
  assign bresp  = bresp_q;
  assign state  = state_q;

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register file: RW registers with byte strobes, RO registers fed
// from hardware, per-register access pulses, independent read/write paths.
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter bit                  PRIV_ONLY  = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [1:0]                     bresp,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_rd_data,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  output logic [NUM_REGS-1:0]            reg_rd_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [IDX_W:0] NUM_REGS_EXT = (IDX_W+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  axi_resp_t               rresp_q, rresp_d;

  logic                    commit;
  logic [ADDR_WIDTH-1:0]   commit_addr;
  logic [2:0]              commit_prot;
  logic [DATA_WIDTH-1:0]   commit_data;
  logic [STRB_W-1:0]       commit_strb;
  axi_resp_t               wr_resp;
  join_state_e             join_state;
  logic [IDX_W-1:0]        widx, ridx;
  axi_resp_t               rd_resp;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    ar_hs;
  logic                    unused_bits;

  axi4_lite_aw_w_join #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_join (
    .clk         (clk),
    .rst         (rst),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .awprot      (awprot),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .bvalid      (bvalid),
    .bready      (bready),
    .bresp       (bresp),
    .commit      (commit),
    .commit_addr (commit_addr),
    .commit_prot (commit_prot),
    .commit_data (commit_data),
    .commit_strb (commit_strb),
    .commit_resp (wr_resp),
    .state       (join_state)
  );

  // Write decode and strobe merge; error responses leave the array untouched.
  always_comb begin
    widx       = commit_addr[ADDR_WIDTH-1:ADDR_LSB];
    wr_resp    = RESP_OKAY;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if ({1'b0, widx} >= NUM_REGS_EXT) begin
      wr_resp = RESP_DECERR;
    end else if (PRIV_ONLY && !commit_prot[PROT_PRIV_BIT]) begin
      wr_resp = RESP_SLVERR;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (widx == IDX_W'(i) && RO_MASK[i]) wr_resp = RESP_SLVERR;
    end
    if (commit && wr_resp == RESP_OKAY) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (widx == IDX_W'(i)) begin
          wr_pulse_d[i] = 1'b1;
          for (int b = 0; b < STRB_W; b++)
            if (commit_strb[b]) regs_d[i][b*8 +: 8] = commit_data[b*8 +: 8];
        end
      end
    end
  end

  // Reads sample regs_q before this edge's write lands, so a same-cycle
  // read of the register being written returns the old contents.
  always_comb begin
    arready      = !rst && !rvalid_q;
    ar_hs        = arvalid && arready;
    ridx         = araddr[ADDR_WIDTH-1:ADDR_LSB];
    rd_resp      = RESP_OKAY;
    rd_word      = '0;
    reg_rd_pulse = '0;
    if ({1'b0, ridx} >= NUM_REGS_EXT)                     rd_resp = RESP_DECERR;
    else if (PRIV_ONLY && !arprot[PROT_PRIV_BIT])         rd_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx == IDX_W'(i)) begin
        rd_word = RO_MASK[i] ? hw_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
        if (ar_hs && rd_resp == RESP_OKAY) reg_rd_pulse[i] = 1'b1;
      end
    end
    if (rd_resp != RESP_OKAY) rd_word = '0;
    rvalid_d = ar_hs || (rvalid_q && !rready);
    rdata_d  = ar_hs ? rd_word : rdata_q;
    rresp_d  = ar_hs ? rd_resp : rresp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q     <= '{default: '0};
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign reg_wr_pulse = wr_pulse_q;
  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;

  assign unused_bits = ^{commit_addr[ADDR_LSB-1:0], commit_prot[2:1],
                         araddr[ADDR_LSB-1:0], arprot[2:1], join_state};

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Scoreboard bench for axi4_lite_reg_slave: 8 x 32-bit registers, register 7
// read-only from hw_rd_data.
`timescale 1ns/1ps
module tb_axi4_lite_reg_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int SW = DW / 8;
  localparam logic [NR-1:0] RO = 8'h80;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  logic clk, rst;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NR*DW-1:0] reg_q, hw_rd_data;
  logic [NR-1:0] reg_wr_pulse, reg_rd_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] model [NR];
  logic [DW-1:0] exp_q [$];
  logic [1:0]    rresp_exp_q [$];
  logic [1:0]    bresp_exp_q [$];
  logic [NR-1:0] ro_v = RO;

  axi4_lite_reg_slave #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_REGS (NR),
    .RO_MASK (RO), .PRIV_ONLY (1'b0)
  ) u_dut (
    .clk (clk), .rst (rst),
    .awvalid (awvalid), .awready (awready), .awaddr (awaddr), .awprot (awprot),
    .wvalid (wvalid), .wready (wready), .wdata (wdata), .wstrb (wstrb),
    .bvalid (bvalid), .bready (bready), .bresp (bresp),
    .arvalid (arvalid), .arready (arready), .araddr (araddr), .arprot (arprot),
    .rvalid (rvalid), .rready (rready), .rdata (rdata), .rresp (rresp),
    .reg_q (reg_q), .hw_rd_data (hw_rd_data),
    .reg_wr_pulse (reg_wr_pulse), .reg_rd_pulse (reg_rd_pulse)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic logic [1:0] predict_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                               input logic [SW-1:0] s);
    int idx;
    idx = int'(a[AW-1:2]);
    if (idx >= NR) return DECERR;
    if (ro_v[idx]) return SLVERR;
    for (int b = 0; b < SW; b++)
      if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    return OKAY;
  endfunction

  function automatic logic [NR-1:0] expect_wr_pulse(input logic [AW-1:0] a);
    int idx;
    idx = int'(a[AW-1:2]);
    if (idx >= NR || ro_v[idx]) return '0;
    return NR'(1) << idx;
  endfunction

  task automatic push_read(input logic [AW-1:0] a);
    int idx;
    idx = int'(a[AW-1:2]);
    if (idx >= NR) begin
      exp_q.push_back('0);
      rresp_exp_q.push_back(DECERR);
    end else begin
      exp_q.push_back(ro_v[idx] ? hw_rd_data[idx*DW +: DW] : model[idx]);
      rresp_exp_q.push_back(OKAY);
    end
  endtask

  // ---------------- drivers (entered and left at posedge + 1) ----------------
  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s);
    bit aw_done, w_done;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    bresp_exp_q.push_back(predict_write(a, d, s));
    awvalid = 1'b1; awaddr = a; awprot = 3'b000;
    wvalid = 1'b1; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 20) begin
      @(negedge clk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge clk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n_tests++;
    if (!(aw_done && w_done)) begin
      n_fail++;
      $display("FAIL write_handshake addr=%h: aw_done=%0d w_done=%0d, required both 1", a, aw_done, w_done);
    end
  endtask

  task automatic drive_read(input logic [AW-1:0] a, output logic [NR-1:0] pulse);
    bit done;
    int cyc;
    done = 0; cyc = 0; pulse = '0;
    push_read(a);
    arvalid = 1'b1; araddr = a; arprot = 3'b000;
    while (!done && cyc < 20) begin
      @(negedge clk);
      if (arready) begin
        done = 1;
        pulse = reg_rd_pulse;
      end
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL read_handshake addr=%h: arready never seen", a);
    end
  endtask

  // ---------------- scoreboard collectors ----------------
  task automatic collect_b(output int lat, output logic [NR-1:0] pulse);
    logic [1:0] e;
    lat = 0;
    @(negedge clk);
    while (!bvalid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    pulse = reg_wr_pulse;
    n_tests++;
    if (!bvalid || bresp_exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL b_response: bvalid=%0d queued=%0d, required bvalid=1", bvalid, bresp_exp_q.size());
    end else begin
      e = bresp_exp_q.pop_front();
      if (bresp !== e) begin
        n_fail++;
        $display("FAIL bresp: got %b, required %b", bresp, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic collect_r(output int lat);
    logic [DW-1:0] ed;
    logic [1:0] er;
    lat = 0;
    @(negedge clk);
    while (!rvalid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    n_tests++;
    if (!rvalid || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL r_response: rvalid=%0d queued=%0d, required rvalid=1", rvalid, exp_q.size());
    end else begin
      ed = exp_q.pop_front();
      er = rresp_exp_q.pop_front();
      if ({rresp, rdata} !== {er, ed}) begin
        n_fail++;
        $display("FAIL rdata: got resp=%b data=%h, required resp=%b data=%h", rresp, rdata, er, ed);
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    hw_rd_data = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, required 00000", {awready, wready, arready, bvalid, rvalid});
    end
    n_tests++;
    if ({bresp, rresp, rdata, reg_wr_pulse, reg_rd_pulse} !== '0 || reg_q !== '0) begin
      n_fail++;
      $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h reg_q=%h, required all 0", bresp, rresp, rdata, reg_q);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 111", {awready, wready, arready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_write_read;
    int lat;
    logic [NR-1:0] pulse;
    drive_write(32'h04, 32'hDEADBEEF, 4'hF);
    collect_b(lat, pulse);
    n_tests++;
    if (lat !== 0 || pulse !== 8'h02) begin
      n_fail++;
      $display("FAIL basic_write_timing: lat=%0d pulse=%b, required lat=0 pulse=00000010", lat, pulse);
    end
    @(negedge clk);
    n_tests++;
    if (reg_wr_pulse !== 8'h00 || reg_q[32 +: 32] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_write_state: pulse=%b reg1=%h, required 0 and deadbeef", reg_wr_pulse, reg_q[32 +: 32]);
    end
    @(posedge clk); #1;
    drive_read(32'h04, pulse);
    n_tests++;
    if (pulse !== 8'h02) begin
      n_fail++;
      $display("FAIL basic_rd_pulse: got %b, required 00000010", pulse);
    end
    collect_r(lat);
    n_tests++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL basic_read_latency: got %0d, required 0", lat);
    end
    drive_write(32'h06, 32'h12345678, 4'h0);
    collect_b(lat, pulse);
    n_tests++;
    if (pulse !== 8'h02) begin
      n_fail++;
      $display("FAIL zero_strobe_pulse: got %b, required 00000010", pulse);
    end
    drive_read(32'h05, pulse);
    collect_r(lat);
  endtask

  task automatic test_w_before_aw;
    int lat;
    bit ok;
    logic [NR-1:0] pulse;
    wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'b0101;
    @(negedge clk);
    @(posedge clk); #1;
    wvalid = 1'b0;
    ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (bvalid || wready || !awready) ok = 0;
      @(posedge clk); #1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL w_held_wait: bvalid=%0d wready=%0d awready=%0d, required 0 0 1", bvalid, wready, awready);
    end
    bresp_exp_q.push_back(predict_write(32'h08, 32'h11223344, 4'b0101));
    awvalid = 1'b1; awaddr = 32'h08; awprot = 3'b000;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0;
    collect_b(lat, pulse);
    n_tests++;
    if (lat !== 0 || pulse !== 8'h04) begin
      n_fail++;
      $display("FAIL w_first_commit: lat=%0d pulse=%b, required 0 and 00000100", lat, pulse);
    end
    @(negedge clk);
    n_tests++;
    if (reg_q[64 +: 32] !== 32'h00220044) begin
      n_fail++;
      $display("FAIL w_first_merge: reg2=%h, required 00220044", reg_q[64 +: 32]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ro_and_decode;
    int lat;
    logic [NR-1:0] pulse;
    hw_rd_data[7*DW +: DW] = 32'hCAFE0001;
    drive_write(32'h1C, 32'h55AA55AA, 4'hF);
    collect_b(lat, pulse);
    n_tests++;
    if (pulse !== 8'h00 || reg_q[7*DW +: DW] !== 32'h0) begin
      n_fail++;
      $display("FAIL ro_write_effect: pulse=%b reg7=%h, required 0 and 0", pulse, reg_q[7*DW +: DW]);
    end
    drive_read(32'h1C, pulse);
    n_tests++;
    if (pulse !== 8'h80) begin
      n_fail++;
      $display("FAIL ro_rd_pulse: got %b, required 10000000", pulse);
    end
    collect_r(lat);
    drive_read(32'h20, pulse);
    n_tests++;
    if (pulse !== 8'h00) begin
      n_fail++;
      $display("FAIL decerr_rd_pulse: got %b, required 0", pulse);
    end
    collect_r(lat);
    drive_write(32'h20, 32'hFFFFFFFF, 4'hF);
    collect_b(lat, pulse);
    n_tests++;
    if (pulse !== 8'h00) begin
      n_fail++;
      $display("FAIL decerr_wr_pulse: got %b, required 0", pulse);
    end
  endtask

  task automatic test_backpressure;
    int lat, pulse_cycles;
    bit ok;
    logic [NR-1:0] pulse;
    bready = 1'b0;
    drive_write(32'h00, 32'hA5A50F0F, 4'hF);
    ok = 1; pulse_cycles = 0;
    repeat (5) begin
      @(negedge clk);
      if (!bvalid || bresp !== OKAY || awready || wready) ok = 0;
      if (reg_wr_pulse !== 8'h00) pulse_cycles++;
    end
    n_tests++;
    if (!ok || pulse_cycles != 1) begin
      n_fail++;
      $display("FAIL b_stall: hold_ok=%0d pulse_cycles=%0d, required 1 and 1", ok, pulse_cycles);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    collect_b(lat, pulse);
    rready = 1'b0;
    drive_read(32'h04, pulse);
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (!rvalid || rdata !== model[1] || rresp !== OKAY || arready) ok = 0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL r_stall: rvalid=%0d rdata=%h arready=%0d, required 1 %h 0", rvalid, rdata, arready, model[1]);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    collect_r(lat);
  endtask

  task automatic test_same_cycle;
    int lat;
    logic [NR-1:0] pulse;
    drive_write(32'h0C, 32'h0000000A, 4'hF);
    collect_b(lat, pulse);
    push_read(32'h0C);
    bresp_exp_q.push_back(predict_write(32'h0C, 32'h00000005, 4'hF));
    rready = 1'b0;
    awvalid = 1'b1; awaddr = 32'h0C; wvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h0C;
    @(negedge clk);
    n_tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++;
      $display("FAIL concurrent_ready: got %b, required 111", {awready, wready, arready});
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    collect_b(lat, pulse);
    rready = 1'b1;
    collect_r(lat);
    @(negedge clk);
    n_tests++;
    if (reg_q[3*DW +: DW] !== 32'h5) begin
      n_fail++;
      $display("FAIL same_cycle_post: reg3=%h, required 00000005", reg_q[3*DW +: DW]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    bit ok;
    logic [NR-1:0] pulse;
    awvalid = 1'b1; awaddr = 32'h10;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0 ||
        reg_q !== '0 || reg_wr_pulse !== '0 || reg_rd_pulse !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: ready=%b valid=%b reg_q=%h, required all 0",
               {awready, wready, arready}, {bvalid, rvalid}, reg_q);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    wvalid = 1'b1; wdata = 32'h00000077; wstrb = 4'hF;
    @(negedge clk);
    @(posedge clk); #1;
    wvalid = 1'b0;
    ok = 1;
    repeat (5) begin
      @(negedge clk);
      if (bvalid) ok = 0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stale_aw_after_reset: bvalid=%0d, required 0", bvalid);
    end
    @(posedge clk); #1;
    bresp_exp_q.push_back(predict_write(32'h14, 32'h00000077, 4'hF));
    awvalid = 1'b1; awaddr = 32'h14;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0;
    collect_b(lat, pulse);
    n_tests++;
    if (pulse !== 8'h20) begin
      n_fail++;
      $display("FAIL post_reset_write_pulse: got %b, required 00100000", pulse);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [AW-1:0] a;
    logic [NR-1:0] pulse, ep;
    for (int k = 0; k < 40; k++) begin
      a = AW'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        ep = expect_wr_pulse(a);
        drive_write(a, $urandom, SW'($urandom_range(0, 15)));
        collect_b(lat, pulse);
        n_tests++;
        if (pulse !== ep || lat !== 0) begin
          n_fail++;
          $display("FAIL rand_write addr=%h: pulse=%b lat=%0d, required %b 0", a, pulse, lat, ep);
        end
      end else begin
        drive_read(a, pulse);
        collect_r(lat);
      end
    end
    drive_read(32'h08, pulse);
    collect_r(lat);
  endtask

  initial begin
    test_reset();
    test_basic_write_read();
    test_w_before_aw();
    test_ro_and_decode();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
